native_stream_out_port: RTL and testbench

NATIVE_STREAM_OUT_PORT -- requirements
Module: native_stream_out_port

---
 rtl/native_port_pkg.sv | 25 ++
 rtl/sync_edge_det.sv | 43 ++++
 rtl/native_stream_out_port.sv | 197 +++++++++++++++++++
 tb/tb_native_stream_out_port.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/native_port_pkg.sv
// Shared definitions for the native stream output port: FSM states,
// read-alignment mode names, the supported LAT range and the sync tap layout.
package native_port_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } port_state_e;

  localparam logic [31:0] MODE_ONCE = "ONCE";
  localparam logic [31:0] MODE_LINE = "LINE";

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 4;

  // One stage of the sync delay line; starve marks a de cycle read from an empty FIFO
  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
    logic starve;
  } sync_tap_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registered rising/falling edge detector. Edges are reported one cycle after
// the new level is sampled. The first sample after reset only primes the
// history, so a level already high at reset release never looks like an edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev_q, prev_d;
  logic valid_q, valid_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Compare the new sample against the previous one once history is valid
  always_comb begin
    prev_d  = sig;
    valid_d = 1'b1;
    rise_d  = valid_q & ~prev_q & sig;
    fall_d  = valid_q & prev_q & ~sig;
  end

  // History and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/native_stream_out_port.sv
// Native video stream output port: reads pixels from a FIFO under the timing
// generator's data enable, realigns syncs and data by LAT cycles (LAT in
// LAT_MIN..LAT_MAX), substitutes FILL on starvation, tracks frame/line
// progress and keeps sticky error flags.
// Optional build macro NATIVE_OUT_LINECHK_EN adds the per-line pixel count check.
module native_stream_out_port
  import native_port_pkg::*;
#(
  parameter int unsigned      DSIZE = 24,
  parameter int unsigned      LAT   = 1,
  parameter logic [31:0]      MODE  = "ONCE",
  parameter logic [DSIZE-1:0] FILL  = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic             in_vsync,
  input  logic             in_hsync,
  input  logic             in_de,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_empty,
  input  logic             err_clr,
  output logic             out_vsync,
  output logic             out_hsync,
  output logic             out_de,
  output logic [DSIZE-1:0] odata,
  output logic             rd_en,
  output logic             falign,
  output logic             lalign,
  output logic             ealign,
  output logic             underflow,
  output logic             line_err,
  output logic             short_frame,
  output logic [15:0]      lcnt
);

  localparam logic LINE_MODE = (MODE == MODE_LINE);

  sync_tap_t [LAT-1:0] tap_q, tap_d;
  logic [DSIZE-1:0]    data_tap;
  port_state_e         state_q, state_d;
  logic [15:0]         lcnt_q, lcnt_d;
  logic                underflow_q, underflow_d;
  logic                short_q, short_d;
  logic                vs_rise, de_fall;
  logic                vs_fall_unused, de_rise_unused;

  assign rd_en = in_de & ~in_empty;

  sync_edge_det u_vs_edge (
    .clk  (clock),
    .rst  (rst),
    .sig  (in_vsync),
    .rise (vs_rise),
    .fall (vs_fall_unused)
  );

  sync_edge_det u_de_edge (
    .clk  (clock),
    .rst  (rst),
    .sig  (in_de),
    .rise (de_rise_unused),
    .fall (de_fall)
  );

  // Sync delay line: LAT stages, starvation tag travels with its de cycle
  always_comb begin
    tap_d    = tap_q;
    tap_d[0] = {in_vsync, in_hsync, in_de, in_de & in_empty};
    for (int unsigned i = 1; i < LAT; i++) begin
      tap_d[i] = tap_q[i-1];
    end
  end

  // FIFO data already lags rd_en by one cycle, so it needs one stage fewer
  generate
    if (LAT == 1) begin : g_data_direct
      assign data_tap = in_data;
    end else begin : g_data_pipe
      logic [LAT-2:0][DSIZE-1:0] data_q, data_d;

      // Data delay line of LAT-1 stages
      always_comb begin
        data_d    = data_q;
        data_d[0] = in_data;
        for (int unsigned i = 1; i < LAT - 1; i++) begin
          data_d[i] = data_q[i-1];
        end
      end

      // Data delay registers
      always_ff @(posedge clock or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
      end

      assign data_tap = data_q[LAT-2];
    end
  endgenerate

  assign out_vsync = tap_q[LAT-1].vs;
  assign out_hsync = tap_q[LAT-1].hs;
  assign out_de    = tap_q[LAT-1].de;
  assign odata     = !tap_q[LAT-1].de    ? '0   :
                     tap_q[LAT-1].starve ? FILL : data_tap;

  assign falign = vs_rise;
  assign lalign = LINE_MODE ? de_fall : 1'b0;

  // Frame FSM, line counter and sticky flags; falign outranks every other event
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    ealign      = 1'b0;
    short_d     = short_q & ~err_clr;
    underflow_d = (underflow_q & ~err_clr) | (in_de & in_empty);
    unique case (state_q)
      IDLE: begin
        if (vs_rise) begin
          state_d = ACTIVE;
          lcnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          lcnt_d  = '0;
          short_d = 1'b1;
        end else if (lcnt_q == vactive) begin
          state_d = DONE;
          ealign  = 1'b1;
        end else if (de_fall && lcnt_q != '1) begin
          lcnt_d = lcnt_q + 16'd1;
        end
      end
      DONE: begin
        if (vs_rise) begin
          state_d = ACTIVE;
          lcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and flag registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      tap_q       <= '0;
      state_q     <= IDLE;
      lcnt_q      <= '0;
      underflow_q <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      underflow_q <= underflow_d;
      short_q     <= short_d;
    end
  end

  assign lcnt        = lcnt_q;
  assign underflow   = underflow_q;
  assign short_frame = short_q;

`ifdef NATIVE_OUT_LINECHK_EN
  logic [15:0] pix_q, pix_d;
  logic        line_err_q, line_err_d;

  // Pixel count per line; restart on the fall pulse, counting a de that is already back
  always_comb begin
    pix_d = pix_q;
    if (de_fall)                     pix_d = {15'd0, in_de};
    else if (in_de && pix_q != '1)   pix_d = pix_q + 16'd1;
    line_err_d = (line_err_q & ~err_clr) | (de_fall & (pix_q != hactive));
  end

  // Pixel counter and line error registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pix_q      <= '0;
      line_err_q <= 1'b0;
    end else begin
      pix_q      <= pix_d;
      line_err_q <= line_err_d;
    end
  end

  assign line_err = line_err_q;
`else
  logic hactive_unused;
  assign hactive_unused = ^hactive;
  assign line_err       = 1'b0;
`endif

endmodule

// File: tb/tb_native_stream_out_port.sv
// Directed bench for native_stream_out_port: instance a is LAT=1/"LINE",
// instance b is LAT=3/"ONCE", both driven by the same stimulus.
module tb_native_stream_out_port;

  localparam logic [23:0] FILL_PIX = 24'hF1F1F1;
`ifdef NATIVE_OUT_LINECHK_EN
  localparam logic LINE_ERR_EXP = 1'b1;
`else
  localparam logic LINE_ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vactive, hactive;
  logic        in_vsync, in_hsync, in_de, in_empty, err_clr;
  logic [23:0] in_data;

  logic        ovs_a, ohs_a, ode_a, rd_a, fal_a, lal_a, eal_a, und_a, ler_a, shf_a;
  logic        ovs_b, ohs_b, ode_b, rd_b, fal_b, lal_b, eal_b, und_b, ler_b, shf_b;
  logic [23:0] od_a, od_b;
  logic [15:0] lc_a, lc_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cn = 0;
  logic [23:0] pix;
  logic [2:0]  sync_hist [0:1023];
  logic [23:0] data_hist [0:1023];

  always #5 clk = ~clk;

  native_stream_out_port #(.DSIZE(24), .LAT(1), .MODE("LINE"), .FILL(FILL_PIX)) u_dut_a (
    .clock(clk), .rst(rst), .vactive(vactive), .hactive(hactive),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .in_data(in_data),
    .in_empty(in_empty), .err_clr(err_clr),
    .out_vsync(ovs_a), .out_hsync(ohs_a), .out_de(ode_a), .odata(od_a), .rd_en(rd_a),
    .falign(fal_a), .lalign(lal_a), .ealign(eal_a), .underflow(und_a),
    .line_err(ler_a), .short_frame(shf_a), .lcnt(lc_a)
  );

  native_stream_out_port #(.DSIZE(24), .LAT(3), .MODE("ONCE"), .FILL(FILL_PIX)) u_dut_b (
    .clock(clk), .rst(rst), .vactive(vactive), .hactive(hactive),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .in_data(in_data),
    .in_empty(in_empty), .err_clr(err_clr),
    .out_vsync(ovs_b), .out_hsync(ohs_b), .out_de(ode_b), .odata(od_b), .rd_en(rd_b),
    .falign(fal_b), .lalign(lal_b), .ealign(eal_b), .underflow(und_b),
    .line_err(ler_b), .short_frame(shf_b), .lcnt(lc_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle: drive inputs, answer the FIFO read, check delayed outputs
  task automatic cyc(input logic v, input logic h, input logic de, input logic e);
    in_vsync = v; in_hsync = h; in_de = de; in_empty = e;
    #1;
    check_eq("rd_en_a", {31'd0, rd_a}, {31'd0, de & ~e});
    check_eq("rd_en_b", {31'd0, rd_b}, {31'd0, de & ~e});
    @(posedge clk);
    sync_hist[cn] = rst ? 3'b000 : {v, h, de};
    data_hist[cn] = e ? FILL_PIX : pix;
    #1;
    in_data = (de && !e) ? pix : 24'h5A5A5A;
    if (de && !e) pix = pix + 24'd1;
    #1;
    check_eq("sync_a", {29'd0, ovs_a, ohs_a, ode_a}, {29'd0, sync_hist[cn]});
    if (sync_hist[cn][0]) check_eq("odata_a", {8'd0, od_a}, {8'd0, data_hist[cn]});
    if (cn >= 2) begin
      check_eq("sync_b", {29'd0, ovs_b, ohs_b, ode_b}, {29'd0, sync_hist[cn-2]});
      if (sync_hist[cn-2][0]) check_eq("odata_b", {8'd0, od_b}, {8'd0, data_hist[cn-2]});
    end
    cn++;
  endtask

  // Vsync pulse of two cycles then blanking; falign follows the first high sample
  task automatic vs_pulse();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("falign_a", {31'd0, fal_a}, 32'd1);
    check_eq("falign_b", {31'd0, fal_b}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("falign_off", {31'd0, fal_a}, 32'd0);
    check_eq("lcnt_clr_a", {16'd0, lc_a}, 32'd0);
    check_eq("lcnt_clr_b", {16'd0, lc_b}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One line of npix pixels (empty_idx marks a starved pixel) plus 3 blanking cycles
  task automatic line(input int npix, input int empty_idx, input logic exp_eal,
                      input logic [15:0] exp_lcnt);
    for (int i = 0; i < npix; i++) cyc(1'b0, 1'b0, 1'b1, i == empty_idx);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("lalign_a", {31'd0, lal_a}, 32'd1);
    check_eq("lalign_b", {31'd0, lal_b}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("ealign_a", {31'd0, eal_a}, {31'd0, exp_eal});
    check_eq("ealign_b", {31'd0, eal_b}, {31'd0, exp_eal});
    check_eq("lcnt_a", {16'd0, lc_a}, {16'd0, exp_lcnt});
    check_eq("lcnt_b", {16'd0, lc_b}, {16'd0, exp_lcnt});
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ealign_end", {31'd0, eal_a}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sync_hist[i] = '0;
      data_hist[i] = '0;
    end
    rst = 1'b1; vactive = 16'd3; hactive = 16'd4; err_clr = 1'b0;
    in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; in_empty = 1'b0;
    in_data = '0; pix = 24'h000100;

    // Reset state
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_outs_a", {24'd0, ovs_a, ohs_a, ode_a, fal_a, lal_a, eal_a, und_a, shf_a},
             32'd0);
    check_eq("rst_lcnt_a", {16'd0, lc_a}, 32'd0);
    check_eq("rst_odata_b", {8'd0, od_b}, 32'd0);
    rst = 1'b0;

    // Sync toggling while idle: delays checked per cycle, lcnt holds in IDLE
    for (int i = 0; i < 6; i++) cyc(1'b0, i[0], i[1], 1'b0);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check_eq("idle_lcnt", {16'd0, lc_a}, 32'd0);
    check_eq("idle_line_err", {31'd0, ler_a}, 32'd0);
    check_eq("idle_underflow", {31'd0, und_a}, 32'd0);

    // Frame 1: pixel 2 of line 0 starved, ealign after the third line
    vs_pulse();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("underflow_set_a", {31'd0, und_a}, 32'd1);
    check_eq("underflow_set_b", {31'd0, und_b}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("l0_lcnt", {16'd0, lc_a}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    line(4, -1, 1'b0, 16'd2);
    line(4, -1, 1'b1, 16'd3);
    // DONE holds the count and gives no further ealign
    line(4, -1, 1'b0, 16'd3);
    check_eq("underflow_sticky", {31'd0, und_a}, 32'd1);
    check_eq("line_err_4pix", {31'd0, ler_a}, 32'd0);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check_eq("underflow_clr_a", {31'd0, und_a}, 32'd0);
    check_eq("underflow_clr_b", {31'd0, und_b}, 32'd0);

    // Frame 2: a short line, then an early vsync after line 1
    vs_pulse();
    check_eq("short_none", {31'd0, shf_a}, 32'd0);
    line(3, -1, 1'b0, 16'd1);
    check_eq("line_err_3pix_a", {31'd0, ler_a}, {31'd0, LINE_ERR_EXP});
    check_eq("line_err_3pix_b", {31'd0, ler_b}, {31'd0, LINE_ERR_EXP});
    vs_pulse();
    check_eq("short_frame_a", {31'd0, shf_a}, 32'd1);
    check_eq("short_frame_b", {31'd0, shf_b}, 32'd1);
    line(4, -1, 1'b0, 16'd1);
    line(4, -1, 1'b0, 16'd2);

    // Reset mid-line with vsync held high across release
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    for (int k = 1; k <= 3; k++) if (cn >= k) sync_hist[cn-k] = '0;
    check_eq("mid_rst_a", {24'd0, ovs_a, ohs_a, ode_a, fal_a, lal_a, eal_a, und_a, shf_a},
             32'd0);
    check_eq("mid_rst_b", {24'd0, ovs_b, ohs_b, ode_b, fal_b, lal_b, eal_b, und_b, shf_b},
             32'd0);
    check_eq("mid_rst_flags", {30'd0, ler_a, ler_b}, 32'd0);
    check_eq("mid_rst_lcnt", {lc_a, lc_b}, 32'd0);
    check_eq("mid_rst_odata", {8'd0, od_a | od_b}, 32'd0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("no_falign_held", {30'd0, fal_a, fal_b}, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("no_falign_low", {30'd0, fal_a, fal_b}, 32'd0);
    vs_pulse();
    line(4, -1, 1'b0, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
